// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector, exception codes, fetch FSM states
// and the fetch-stage payload handed to IF/ID.
package cpu_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXR_W = 6;

  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'hBFC0_0000;

  localparam logic [EXR_W-1:0] EXR_NONE = 6'd0;
  localparam logic [EXR_W-1:0] EXR_ADEL = 6'd4;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_CANCEL
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  inst;
    logic             exr_valid;
    logic [EXR_W-1:0] exr_type;
    logic [XLEN-1:0]  exr_a0;
  } fetch_out_t;

endpackage

// File: rtl/inst_fetch_if.sv
// sram-like instruction port: fetch stage is master, bus bridge is slave.
interface inst_fetch_if;
  import cpu_defs::*;

  logic            inst_req;
  logic [XLEN-1:0] inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [XLEN-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: owns the PC, issues one fetch at a time,
// handles delayed branches, flush with in-flight cancellation and AdEL.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        stall,
  input  logic              branch_valid,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              flush,
  input  logic [XLEN-1:0]   flush_target,
  inst_fetch_if.master      ibus,
  output logic [XLEN-1:0]   output_addr,
  output logic [XLEN-1:0]   output_inst,
  output logic              output_exr_valid,
  output logic [EXR_W-1:0]  output_exr_type,
  output logic [XLEN-1:0]   output_exr_a0,
  output logic              stall_req
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] inst_buf;
  logic            pb_valid;
  logic [XLEN-1:0] pb_target;
  logic            cancel_acc;

  logic            misaligned;
  logic            fetch_ready;
  logic            advance;
  logic [XLEN-1:0] next_pc;
  fetch_out_t      fout;

  logic unused_stall;
  assign unused_stall = ^stall[4:1];

  // Fetch readiness and next-PC selection
  always_comb begin
    misaligned  = (state == FS_REQ) && (pc[1:0] != 2'b00);
    fetch_ready = ((state == FS_WAIT) && ibus.inst_data_ok) ||
                  (state == FS_HOLD) || misaligned;
    advance     = fetch_ready && !stall[0] && !flush;
    if (flush)             next_pc = flush_target;
    else if (pb_valid)     next_pc = pb_target;
    else if (branch_valid) next_pc = branch_target;
    else                   next_pc = pc + 32'd4;
  end

  // Presented payload; a flush cycle is always a bubble
  always_comb begin
    fout      = '0;
    fout.addr = pc;
    if (fetch_ready && !flush) begin
      if (misaligned) begin
        fout.exr_valid = 1'b1;
        fout.exr_type  = EXR_ADEL;
        fout.exr_a0    = pc;
      end else if (state == FS_HOLD) begin
        fout.inst = inst_buf;
      end else begin
        fout.inst = ibus.inst_rdata;
      end
    end
  end

  assign output_addr      = fout.addr;
  assign output_inst      = fout.inst;
  assign output_exr_valid = fout.exr_valid;
  assign output_exr_type  = fout.exr_type;
  assign output_exr_a0    = fout.exr_a0;
  assign stall_req        = !fetch_ready && !flush;

  // A cancelled request that was never accepted must still finish its handshake
  assign ibus.inst_req  = ((state == FS_REQ) && !misaligned) ||
                          ((state == FS_CANCEL) && !cancel_acc);
  assign ibus.inst_addr = req_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FS_REQ;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      inst_buf   <= '0;
      pb_valid   <= 1'b0;
      pb_target  <= '0;
      cancel_acc <= 1'b0;
    end else if (flush) begin
      pc       <= next_pc;
      pb_valid <= 1'b0;
      unique case (state)
        FS_REQ: begin
          if (misaligned) begin
            req_addr <= next_pc;
          end else begin
            state      <= FS_CANCEL;
            cancel_acc <= ibus.inst_addr_ok;
          end
        end
        FS_WAIT: begin
          if (ibus.inst_data_ok) begin
            state    <= FS_REQ;
            req_addr <= next_pc;
          end else begin
            state      <= FS_CANCEL;
            cancel_acc <= 1'b1;
          end
        end
        FS_HOLD: begin
          state    <= FS_REQ;
          req_addr <= next_pc;
        end
        FS_CANCEL: begin
          if (cancel_acc && ibus.inst_data_ok) begin
            state    <= FS_REQ;
            req_addr <= next_pc;
          end else if (!cancel_acc && ibus.inst_addr_ok) begin
            cancel_acc <= 1'b1;
          end
        end
      endcase
    end else if (advance) begin
      pc       <= next_pc;
      req_addr <= next_pc;
      state    <= FS_REQ;
      pb_valid <= 1'b0;
    end else begin
      // Branch resolved while the delay slot is still in flight
      if (branch_valid) begin
        pb_valid  <= 1'b1;
        pb_target <= branch_target;
      end
      unique case (state)
        FS_REQ: begin
          if (!misaligned && ibus.inst_addr_ok) state <= FS_WAIT;
        end
        FS_WAIT: begin
          if (ibus.inst_data_ok) begin
            state    <= FS_HOLD;
            inst_buf <= ibus.inst_rdata;
          end
        end
        FS_HOLD: begin
          state <= FS_HOLD;
        end
        FS_CANCEL: begin
          if (!cancel_acc) begin
            if (ibus.inst_addr_ok) cancel_acc <= 1'b1;
          end else if (ibus.inst_data_ok) begin
            state    <= FS_REQ;
            req_addr <= pc;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the PC and issues word fetches on the sram-like instruction port. It hands {pc, instruction, exception} to IF/ID and raises a stall request while a fetch is outstanding. It handles branch redirects (delay-slot semantics), exception/eret flushes with cancellation of in-flight fetches, and PC misalignment (AdEL).

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC value after reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- stall  in  5  pipeline stall vector; stall[0] holds this stage.
- branch_valid  in  1  ID resolved a taken branch/jump this cycle.
- branch_target  in  32  target for branch_valid.
- flush  in  1  exception/eret flush; highest priority.
- flush_target  in  32  new PC for flush.
- inst_req  out  1  sram-like request.
- inst_addr  out  32  request address.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  read data valid.
- inst_rdata  in  32  read data.
- output_addr  out  32  PC of the presented instruction.
- output_inst  out  32  presented instruction; 0 when none.
- output_exr_valid  out  1  fetch exception.
- output_exr_type  out  6  exception code.
- output_exr_a0  out  32  BadVAddr.
- stall_req  out  1  instruction not yet available.

## Operation
- Registers: pc, req_addr, inst_buf, pending_branch (valid + target), state.
- State REQ: inst_req=1, inst_addr=req_addr. inst_addr_ok → WAIT. Address is held stable until accepted.
- State WAIT: inst_data_ok → fetch ready. Data goes to output_inst the same cycle.
- If stall[0]=1 at data arrival → HOLD, with data captured in inst_buf.
- State HOLD: presents inst_buf until stall[0]=0.
- State CANCEL: a flushed fetch is outstanding. Its inst_data_ok is discarded, then go to REQ with req_addr=pc.
  - If the flush hit REQ before acceptance, the old request completes acceptance and then enters CANCEL.
- fetch_ready = (WAIT & inst_data_ok) | HOLD | misaligned. stall_req = !fetch_ready & !flush.
- Misaligned: pc[1:0]≠0. No bus request is issued. Present exr_valid=1, exr_type=EXR_ADEL (6'd4), exr_a0=pc, inst=0.
- PC advance happens on fetch_ready & !stall[0]. next_pc priority:
  - flush → flush_target
  - else pending_branch → its target
  - else pc+4
- After an advance, req_addr=next_pc and state goes to REQ.
- branch_valid is recorded in pending_branch. It is consumed at the next advance: the delay slot is the in-progress fetch. branch_valid and an advance in the same cycle means the target is used immediately.
- flush in any state: pc=flush_target and pending_branch is cleared.
  - Outstanding request (REQ, WAIT without data_ok) → CANCEL, else REQ.
  - Outputs are zero (bubble) during the flush cycle.
- When not fetch_ready: output_inst=0 and output_exr_*=0. output_addr is always pc.
- PC arithmetic is 32-bit with wrap: 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values: pc=RESET_PC, state=REQ, inst_req=1 on the first cycle after reset, stall_req=1, output_inst=0, exr outputs 0, pending_branch invalid.
- Minimum fetch is 2 cycles when addr_ok is on the request cycle and data_ok follows the next cycle. Zero-wait returns give one instruction every 2 cycles.
- Same-cycle addr_ok and data_ok for different requests cannot occur: only one request is outstanding.
- reset mid-fetch: state returns to REQ. A late data_ok is ignored until the new request is accepted; the bridge is reset with the core.

## Structure
- Shared package cpu_defs: RESET_PC default, EXR_ADEL/EXR_* 6-bit codes, and a fetch-state enum (REQ, WAIT, HOLD, CANCEL).
- Single module, no sub-modules. Next-PC mux is inline combinational logic.

## Test plan
- Reset → first inst_addr=BFC00000. addr_ok the same cycle, data_ok next with 0x24080001 → output_inst=0x24080001, output_addr=BFC00000. Next request is at BFC00004.
- Data arrives with stall[0]=1 for 3 cycles → HOLD. Instruction is held stable and stall_req=0. Advance on the first cycle with stall[0]=0.
- branch_valid (target 0x80001000) during the delay-slot WAIT → delay slot completes, next inst_addr=0x80001000.
- flush (target 0xBFC00380) during WAIT → CANCEL. The stale data_ok produces no output, then a request at BFC00380. A pending branch is dropped.
- flush_target 0x80000002 → no inst_req. output_exr_valid=1, type=4, a0=0x80000002, inst=0.
- Random addr_ok/data_ok delays of 0-5 cycles over 1000 sequential fetches → each output_addr matches its data with no drops or duplicates.
